// File: rtl/parity_fifo_arb.sv
// Per-channel parity-checked FIFOs merged by a round-robin arbiter
// into one registered output stream with saturating error counters.
module parity_fifo_arb #(
  parameter int    DATA_WIDTH        = 8,
  parameter int    DEPTH             = 4,
  parameter int    NUM_CH            = 2,
  parameter string PARITY_MODE       = "EVEN",
  parameter string PARITY_BIT_CHOICE = "MSB",
  parameter int    DROP_ON_ERROR     = 1,
  parameter int    ERR_CNT_WIDTH     = 8,
  localparam int   CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int   LW = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CH-1:0]               push_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    push_data_i,
  output logic [NUM_CH-1:0]               push_grant_o,
  output logic                            valid_o,
  output logic [DATA_WIDTH-2:0]           data_o,
  output logic [CW-1:0]                   ch_o,
  output logic                            err_o,
  input  logic                            grant_i,
  input  logic                            err_clr_i,
  output logic [NUM_CH*ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [NUM_CH*LW-1:0]            level_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = DATA_WIDTH - 1;
  localparam bit ODD = (PARITY_MODE == "ODD");
  localparam bit MSB = (PARITY_BIT_CHOICE == "MSB");
  localparam bit DRP = (DROP_ON_ERROR != 0);

  logic [DATA_WIDTH-1:0]    mem [NUM_CH][DEPTH];
  logic [AW-1:0]            rd_ptr [NUM_CH];
  logic [AW-1:0]            wr_ptr [NUM_CH];
  logic [LW-1:0]            level [NUM_CH];
  logic [ERR_CNT_WIDTH-1:0] cnt [NUM_CH];
  logic [DATA_WIDTH-1:0]    head [NUM_CH];
  logic [CW-1:0]            rr;
  logic [CW-1:0]            sel;
  logic                     found;
  logic                     load;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] bad;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] inc;

  function automatic logic [PW-1:0] strip(
    input logic [DATA_WIDTH-1:0] w
  );
    return MSB ? w[DATA_WIDTH-2:0] : w[DATA_WIDTH-1:1];
  endfunction

  assign push_grant_o = reset_n ? ~full : '0;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      head[c] = mem[c][rd_ptr[c]];
      full[c] = (level[c] == LW'(DEPTH));
      bad[c]  = (level[c] != '0) &&
                ((^head[c]) != ODD);
      drop[c] = DRP && bad[c];
      elig[c] = (level[c] != '0) && !drop[c];
      push[c] = push_valid_i[c] && push_grant_o[c];
      level_o[c*LW +: LW] = level[c];
      err_cnt_o[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = cnt[c];
    end
  end

  // Search starts just after the last winner.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(rr) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
    load = (!valid_o || grant_i) && found;
    pop  = drop;
    inc  = drop;
    if (load) begin
      pop[sel] = 1'b1;
      inc[sel] = bad[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        level[c]  <= '0;
        cnt[c]    <= '0;
      end
      rr      <= CW'(NUM_CH - 1);
      valid_o <= 1'b0;
      data_o  <= '0;
      ch_o    <= '0;
      err_o   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <=
            push_data_i[c*DATA_WIDTH +: DATA_WIDTH];
          wr_ptr[c] <= wr_ptr[c] + 1'b1;
        end
        if (pop[c])
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c])
          level[c] <= level[c] + 1'b1;
        else if (!push[c] && pop[c])
          level[c] <= level[c] - 1'b1;
        // A clear that meets an increment leaves a count of one.
        if (err_clr_i)
          cnt[c] <= inc[c] ? ERR_CNT_WIDTH'(1) : '0;
        else if (inc[c] && cnt[c] != '1)
          cnt[c] <= cnt[c] + 1'b1;
      end
      if (load) begin
        valid_o <= 1'b1;
        data_o  <= strip(head[sel]);
        ch_o    <= sel;
        err_o   <= bad[sel];
        rr      <= sel;
      end else if (grant_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_fifo_arb.sv
// Randomized bench for parity_fifo_arb: a drop-mode and a flag-mode
// instance share stimulus and are checked against queue models.
module tb_parity_fifo_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pv;
  logic [15:0] pd;
  logic        gi;
  logic        clr;

  logic [1:0]        pg [2];
  logic [1:0]        vo;
  logic [1:0][6:0]   dat;
  logic [1:0]        chn;
  logic [1:0]        er;
  logic [1:0][15:0]  ec;
  logic [1:0][5:0]   lv;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] mq [2][2][$];
  bit         m_vo  [2];
  logic [6:0] m_dat [2];
  int         m_ch  [2];
  bit         m_err [2];
  int         m_rr  [2];
  int         m_cnt [2][2];

  always #5 clk = ~clk;

  parity_fifo_arb #(.DROP_ON_ERROR(1)) u_drop (
    .clk(clk), .reset_n(rst_n),
    .push_valid_i(pv), .push_data_i(pd),
    .push_grant_o(pg[0]), .valid_o(vo[0]),
    .data_o(dat[0]), .ch_o(chn[0]), .err_o(er[0]),
    .grant_i(gi), .err_clr_i(clr),
    .err_cnt_o(ec[0]), .level_o(lv[0])
  );

  parity_fifo_arb #(.DROP_ON_ERROR(0)) u_flag (
    .clk(clk), .reset_n(rst_n),
    .push_valid_i(pv), .push_data_i(pd),
    .push_grant_o(pg[1]), .valid_o(vo[1]),
    .data_o(dat[1]), .ch_o(chn[1]), .err_o(er[1]),
    .grant_i(gi), .err_clr_i(clr),
    .err_cnt_o(ec[1]), .level_o(lv[1])
  );

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h",
               nm, i, $time, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit drop;
    bit [1:0] el, inc, gr;
    int sel;
    logic [7:0] w;
    drop = (i == 0);
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        mq[i][c].delete();
        m_cnt[i][c] = 0;
      end
      m_vo[i] = 0; m_dat[i] = '0; m_ch[i] = 0;
      m_err[i] = 0; m_rr[i] = 1;
      return;
    end
    el = '0; inc = '0;
    for (int c = 0; c < 2; c++) begin
      gr[c] = mq[i][c].size() < 4;
      if (mq[i][c].size() > 0) begin
        if (drop && ^mq[i][c][0]) begin
          void'(mq[i][c].pop_front());
          inc[c] = 1'b1;
        end else begin
          el[c] = 1'b1;
        end
      end
    end
    if ((!m_vo[i] || gi) && el != 0) begin
      sel = el[(m_rr[i] + 1) % 2] ? (m_rr[i] + 1) % 2 : m_rr[i];
      w = mq[i][sel].pop_front();
      m_vo[i]  = 1;
      m_dat[i] = w[6:0];
      m_ch[i]  = sel;
      m_err[i] = ^w;
      if (^w) inc[sel] = 1'b1;
      m_rr[i] = sel;
    end else if (gi) begin
      m_vo[i] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      if (clr) m_cnt[i][c] = int'(inc[c]);
      else if (inc[c] && m_cnt[i][c] < 255) m_cnt[i][c]++;
      if (pv[c] && gr[c]) mq[i][c].push_back(pd[c*8 +: 8]);
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("valid", i, 32'(vo[i]), 32'(m_vo[i]));
        chk("data", i, 32'(dat[i]), 32'(m_dat[i]));
        chk("ch", i, 32'(chn[i]), 32'(m_ch[i]));
        chk("err", i, 32'(er[i]), 32'(m_err[i]));
        for (int c = 0; c < 2; c++) begin
          chk("grant", i, 32'(pg[i][c]),
              32'(rst_n && mq[i][c].size() < 4));
          chk("cnt", i, 32'(ec[i][c*8 +: 8]),
              32'(m_cnt[i][c]));
          chk("level", i, 32'(lv[i][c*3 +: 3]),
              32'(mq[i][c].size()));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] word(input bit good);
    logic [7:0] w;
    w = 8'($urandom);
    w[7] = good ? ^w[6:0] : ~^w[6:0];
    return w;
  endfunction

  initial begin
    rst_n = 0; pv = '0; pd = '0; gi = 0; clr = 0;
    tick(); tick();
    chk_en = 1;
    rst_n = 1;
    tick();

    pv = 2'b01; pd = 16'h0003; gi = 1;
    tick();
    pd[7:0] = 8'h81;
    tick();
    chk("d1_valid", 0, 32'(vo[0]), 32'h1);
    chk("d1_data0", 0, 32'(dat[0]), 32'h03);
    pv = '0;
    tick();
    chk("d1_data1", 0, 32'(dat[0]), 32'h01);
    chk("d1_ch", 0, 32'(chn[0]), 32'h0);
    tick();

    pv = 2'b10; pd[15:8] = 8'h83;
    tick();
    chk("d2_lvl1", 0, 32'(lv[0][5:3]), 32'h1);
    pv = '0;
    tick();
    chk("d2_lvl0", 0, 32'(lv[0][5:3]), 32'h0);
    chk("d2_cnt", 0, 32'(ec[0][15:8]), 32'h1);
    chk("d2_novalid", 0, 32'(vo[0]), 32'h0);
    chk("d2_fdata", 1, 32'(dat[1]), 32'h03);
    chk("d2_ferr", 1, 32'(er[1]), 32'h1);
    pv = 2'b10; pd[15:8] = 8'h05;
    tick();
    pv = '0;
    tick();
    chk("d2_data", 0, 32'(dat[0]), 32'h05);
    chk("d2_ch", 0, 32'(chn[0]), 32'h1);
    tick(); tick();

    gi = 0; pv = 2'b11;
    repeat (3) begin
      pd = {word(1), word(1)};
      tick();
    end
    pv = '0; gi = 1;
    repeat (10) tick();
    gi = 0; pv = 2'b01;
    repeat (6) begin
      pd[7:0] = word(1);
      tick();
    end
    pv = '0;
    chk("d3_lvl", 0, 32'(lv[0][2:0]), 32'h4);
    chk("d3_full", 0, 32'(pg[0][0]), 32'h0);
    chk("d3_hold", 0, 32'(vo[0]), 32'h1);
    tick(); tick();
    gi = 1;
    repeat (8) tick();

    pv = 2'b01; pd[7:0] = 8'h83;
    tick();
    pv = '0;
    tick();
    chk("d4_data", 1, 32'(dat[1]), 32'h03);
    chk("d4_err", 1, 32'(er[1]), 32'h1);
    chk("d4_cnt", 1, 32'(ec[1][7:0]), 32'h1);
    pv = 2'b01;
    repeat (256) tick();
    pv = '0;
    tick(); tick();
    chk("d4_sat", 0, 32'(ec[0][7:0]), 32'hff);
    chk("d4_sat", 1, 32'(ec[1][7:0]), 32'hff);
    pv = 2'b01;
    tick();
    pv = '0; clr = 1;
    tick();
    clr = 0;
    chk("d4_clr", 0, 32'(ec[0][7:0]), 32'h1);
    chk("d4_clr", 1, 32'(ec[1][7:0]), 32'h1);
    chk("d4_clr1", 0, 32'(ec[0][15:8]), 32'h0);
    tick();

    gi = 0; pv = 2'b01;
    pd[7:0] = word(1); tick();
    pd[7:0] = word(1); tick();
    pv = '0; rst_n = 0;
    #1;
    chk("d5_pg_rst", 0, 32'(pg[0]), 32'h0);
    tick();
    chk("d5_valid", 0, 32'(vo[0]), 32'h0);
    chk("d5_lvl", 0, 32'(lv[0]), 32'h0);
    chk("d5_cnt", 1, 32'(ec[1]), 32'h0);
    rst_n = 1;
    #1;
    chk("d5_pg", 0, 32'(pg[0]), 32'h3);
    pv = 2'b11; pd = {word(1), word(1)}; gi = 1;
    tick();
    pv = '0;
    tick();
    chk("d5_first", 0, 32'(chn[0]), 32'h0);
    chk("d5_fval", 0, 32'(vo[0]), 32'h1);
    repeat (3) tick();

    repeat (2500) begin
      pv    = 2'($urandom);
      pd    = {word($urandom_range(0, 4) != 0),
               word($urandom_range(0, 4) != 0)};
      gi    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1; pv = '0; gi = 1; clr = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
